// File: rtl/tx_frame_arbiter_if.sv
// Requester buses plus the byte-wide tx handshake toward the UART core.
// The arbiter drives through master; the requesters/UART side uses slave.
interface tx_frame_arbiter_if #(
    parameter int N_SRC = 21
);
    logic [N_SRC-1:0]   have_msg_bus;
    logic [8*N_SRC-1:0] data_bus;
    logic [8*N_SRC-1:0] len_bus;
    logic [N_SRC-1:0]   rdreq_bus;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic               busy;
    logic [7:0]         grant_idx;

    modport master (
        input  have_msg_bus, data_bus, len_bus, tx_ready,
        output rdreq_bus, tx_data, tx_valid, busy, grant_idx
    );

    modport slave (
        output have_msg_bus, data_bus, len_bus, tx_ready,
        input  rdreq_bus, tx_data, tx_valid, busy, grant_idx
    );
endinterface

// File: rtl/tx_frame_arbiter.sv
// Round-robin framer: sync, addr, len, payload, xor. tx_valid rises 1 clk after grant;
// holds tx_data while !tx_ready; payload moves at most 1 byte per 2 clk.
module tx_frame_arbiter #(
    parameter int         N_SRC = 21,
    parameter logic [7:0] SYNC  = 8'h55
) (
    input  logic               clk,
    input  logic               rst,
    tx_frame_arbiter_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_CSUM
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] ptr_q, ptr_d;
    logic [7:0] grant_q, grant_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] csum_q, csum_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_valid_q, tx_valid_d;
    logic       busy_q, busy_d;

    logic       any_req;
    logic       found_hi;
    logic [7:0] pick_hi, pick_lo, pick;
    logic [7:0] pick_len;
    logic [7:0] head_byte;
    logic       xfer;

    assign any_req   = |bus.have_msg_bus;
    assign pick      = found_hi ? pick_hi : pick_lo;
    assign pick_len  = 8'(bus.len_bus >> {pick, 3'b000});
    assign head_byte = 8'(bus.data_bus >> {grant_q, 3'b000});
    assign xfer      = tx_valid_q & bus.tx_ready;

    // Descending scan so the lowest index wins; prefer indices above the last grant.
    always_comb begin
        found_hi = 1'b0;
        pick_hi  = '0;
        pick_lo  = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (bus.have_msg_bus[i]) begin
                pick_lo = 8'(i);
                if (i > int'(ptr_q)) begin
                    found_hi = 1'b1;
                    pick_hi  = 8'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= 8'(N_SRC - 1);
            grant_q    <= '0;
            cnt_q      <= '0;
            csum_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            csum_q     <= csum_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        csum_d     = csum_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;

        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    grant_d    = pick;
                    ptr_d      = pick;
                    cnt_d      = pick_len;
                    csum_d     = '0;
                    busy_d     = 1'b1;
                    tx_data_d  = SYNC;
                    tx_valid_d = 1'b1;
                    state_d    = S_SYNC;
                end
            end
            S_SYNC: begin
                if (xfer) begin
                    tx_data_d = grant_q;
                    state_d   = S_ADDR;
                end
            end
            S_ADDR: begin
                if (xfer) begin
                    tx_data_d = cnt_q;
                    csum_d    = csum_q ^ grant_q;
                    state_d   = S_LEN;
                end
            end
            S_LEN: begin
                if (xfer) begin
                    csum_d = csum_q ^ cnt_q;
                    if (cnt_q != 8'd0) begin
                        tx_data_d = head_byte;
                        state_d   = S_DATA;
                    end else begin
                        tx_data_d = csum_q ^ cnt_q;
                        state_d   = S_CSUM;
                    end
                end
            end
            S_DATA: begin
                // A valid-low cycle here is the refresh slot after a pop.
                if (!tx_valid_q) begin
                    tx_data_d  = head_byte;
                    tx_valid_d = 1'b1;
                end else if (xfer) begin
                    csum_d = csum_q ^ tx_data_q;
                    cnt_d  = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        tx_data_d = csum_q ^ tx_data_q;
                        state_d   = S_CSUM;
                    end else begin
                        tx_valid_d = 1'b0;
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    tx_valid_d = 1'b0;
                    busy_d     = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.rdreq_bus = (state_q == S_DATA && xfer) ? (N_SRC'(1) << grant_q) : '0;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.busy      = busy_q;
    assign bus.grant_idx = grant_q;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Bench for tx_frame_arbiter: requester buffers modelled as byte arrays, frames checked
// against a spec-level frame builder and cyclic-priority grant model.
module tb_tx_frame_arbiter;
    localparam int N  = 21;
    localparam int LW = 8 * N;

    logic clk = 1'b0;
    logic rst;

    tx_frame_arbiter_if #(.N_SRC(N)) bus ();

    tx_frame_arbiter #(.N_SRC(N), .SYNC(8'h55)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem     [N][256];
    logic [7:0] base    [N] = '{default: 8'd0};
    logic [7:0] pop_cnt [N] = '{default: 8'd0};

    for (genvar g = 0; g < N; g++) begin : g_head
        assign bus.data_bus[g*8 +: 8] = mem[g][pop_cnt[g] - base[g]];
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++)
            if (bus.rdreq_bus[i]) pop_cnt[i] <= pop_cnt[i] + 8'd1;
    end

    logic [7:0] cap[$];
    int         mon_err = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'd0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!bus.tx_valid || bus.tx_data != prev_data)) mon_err++;
            if ($countones(bus.rdreq_bus) > 1) mon_err++;
            if (bus.rdreq_bus != '0 &&
                (!(bus.tx_valid && bus.tx_ready) || bus.rdreq_bus != (N'(1) << bus.grant_idx)))
                mon_err++;
            if (bus.tx_valid && bus.tx_ready) cap.push_back(bus.tx_data);
            prev_stall = bus.tx_valid && !bus.tx_ready;
            prev_data  = bus.tx_data;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    logic [7:0] exp_q[$];
    int         gq[$];
    int         model_ptr;

    task automatic put_byte(input int i, input int k, input logic [7:0] b);
        mem[i][k] = b;
    endtask

    task automatic set_len(input int i, input logic [7:0] v);
        bus.len_bus = (bus.len_bus & ~(LW'(8'hFF) << (i * 8))) | (LW'(v) << (i * 8));
    endtask

    // Expected frame: sync, addr, len, payload, xor of everything but sync.
    task automatic add_exp(input int idx, input int len, input int off);
        logic [7:0] x;
        x = 8'(idx) ^ 8'(len);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'(idx));
        exp_q.push_back(8'(len));
        for (int k = 0; k < len; k++) begin
            exp_q.push_back(mem[idx][off + k]);
            x ^= mem[idx][off + k];
        end
        exp_q.push_back(x);
    endtask

    task automatic cmp_stream(input string name, input int start);
        chk($sformatf("%s count", name), 64'(cap.size() - start), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++)
            chk($sformatf("%s byte%0d", name, k),
                (start + k < cap.size()) ? 64'(cap[start + k]) : 64'h100, 64'(exp_q[k]));
        exp_q.delete();
    endtask

    function automatic int rr_next(input logic [N-1:0] pend, input int last);
        for (int k = 1; k <= N; k++)
            if (pend[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic run_frames(input int nframes, input bit bp, input bit clr, input int budget);
        int  got;
        int  cyc;
        bit  was_busy;
        got = 0;
        cyc = 0;
        was_busy = 1'b0;
        while (1) begin
            @(posedge clk);
            #1;
            bus.tx_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (bus.busy && !was_busy) begin
                gq.push_back(int'(bus.grant_idx));
                got++;
                if (clr) bus.have_msg_bus &= ~(N'(1) << bus.grant_idx);
            end
            was_busy = bus.busy;
            if (got >= nframes && !bus.busy) break;
            cyc++;
            if (cyc > budget) begin
                chk("frame timeout", 64'(cyc), 64'(budget));
                break;
            end
        end
        bus.tx_ready = 1'b1;
    endtask

    typedef struct packed {
        logic [7:0]  idx;
        logic [7:0]  len;
        logic [31:0] pay;
        logic [63:0] frame;
        logic [7:0]  flen;
        logic        bp;
    } vec_t;

    vec_t       vec [5];
    int         start, start2, p0, cyc;
    logic [N-1:0] m, pend;
    int         lens [N];
    int         order[$];
    int         rr_exp [4];

    initial begin
        vec[0] = '{idx: 8'd4,  len: 8'd2, pay: 32'h0000_3412, frame: 64'h0000_2034_1202_0455, flen: 8'd6, bp: 1'b0};
        vec[1] = '{idx: 8'd0,  len: 8'd0, pay: 32'h0,         frame: 64'h0000_0000_0000_0055, flen: 8'd4, bp: 1'b0};
        vec[2] = '{idx: 8'd20, len: 8'd3, pay: 32'h0000_FFA5, frame: 64'h004D_00FF_A503_1455, flen: 8'd7, bp: 1'b0};
        vec[3] = '{idx: 8'd7,  len: 8'd1, pay: 32'h0000_0007, frame: 64'h0000_0001_0701_0755, flen: 8'd5, bp: 1'b1};
        vec[4] = '{idx: 8'd4,  len: 8'd2, pay: 32'h0000_3412, frame: 64'h0000_2034_1202_0455, flen: 8'd6, bp: 1'b1};
        rr_exp = '{1, 3, 20, 1};

        rst = 1'b1;
        bus.have_msg_bus = '0;
        bus.len_bus = '0;
        bus.tx_ready = 1'b0;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 256; k++) mem[i][k] = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset tx_valid", 64'(bus.tx_valid), 64'd0);
        chk("reset tx_data", 64'(bus.tx_data), 64'd0);
        chk("reset rdreq", 64'(bus.rdreq_bus), 64'd0);
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset grant", 64'(bus.grant_idx), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.tx_ready = 1'b1;

        // Round-robin with three requesters held high, fresh pointer after reset.
        foreach (rr_exp[j]) begin
            put_byte(rr_exp[j], (j == 3) ? 1 : 0, 8'(8'h30 + j));
        end
        set_len(1, 8'd1);
        set_len(3, 8'd1);
        set_len(20, 8'd1);
        base[1] = pop_cnt[1];
        base[3] = pop_cnt[3];
        base[20] = pop_cnt[20];
        start = cap.size();
        gq.delete();
        bus.have_msg_bus = (N'(1) << 1) | (N'(1) << 3) | (N'(1) << 20);
        run_frames(4, 1'b0, 1'b0, 400);
        bus.have_msg_bus = '0;
        chk("rr grants", 64'(gq.size()), 64'd4);
        for (int j = 0; j < 4; j++)
            chk($sformatf("rr grant%0d", j), (j < gq.size()) ? 64'(gq[j]) : 64'hFFFF, 64'(rr_exp[j]));
        add_exp(1, 1, 0);
        add_exp(3, 1, 0);
        add_exp(20, 1, 0);
        add_exp(1, 1, 1);
        cmp_stream("rr", start);
        model_ptr = 1;

        // Table vectors: single requester, fixed frames.
        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < 4; k++) put_byte(int'(vec[v].idx), k, 8'(vec[v].pay >> (k * 8)));
            set_len(int'(vec[v].idx), vec[v].len);
            base[vec[v].idx] = pop_cnt[vec[v].idx];
            p0 = int'(pop_cnt[vec[v].idx]);
            start = cap.size();
            gq.delete();
            bus.have_msg_bus = N'(1) << vec[v].idx;
            run_frames(1, vec[v].bp, 1'b1, 400);
            chk($sformatf("vec%0d count", v), 64'(cap.size() - start), 64'(vec[v].flen));
            for (int k = 0; k < int'(vec[v].flen); k++)
                chk($sformatf("vec%0d byte%0d", v, k),
                    (start + k < cap.size()) ? 64'(cap[start + k]) : 64'h100,
                    64'(8'(vec[v].frame >> (k * 8))));
            chk($sformatf("vec%0d pops", v), 64'(8'(int'(pop_cnt[vec[v].idx]) - p0)), 64'(vec[v].len));
            chk($sformatf("vec%0d grant", v), (gq.size() > 0) ? 64'(gq[0]) : 64'hFFFF, 64'(vec[v].idx));
            chk($sformatf("vec%0d idle", v), 64'({bus.busy, bus.tx_valid}), 64'd0);
            model_ptr = int'(vec[v].idx);
        end

        // Grant latency and length latch: len changes 3 -> 7 after the grant.
        for (int k = 0; k < 7; k++) put_byte(4, k, 8'(8'hC1 + k));
        set_len(4, 8'd3);
        base[4] = pop_cnt[4];
        p0 = int'(pop_cnt[4]);
        start = cap.size();
        gq.delete();
        @(posedge clk);
        #1;
        bus.have_msg_bus = N'(1) << 4;
        @(negedge clk);
        chk("latency valid low", 64'(bus.tx_valid), 64'd0);
        @(negedge clk);
        chk("latency valid", 64'(bus.tx_valid), 64'd1);
        chk("latency sync", 64'(bus.tx_data), 64'h55);
        chk("latency grant", 64'(bus.grant_idx), 64'd4);
        chk("latency busy", 64'(bus.busy), 64'd1);
        set_len(4, 8'd7);
        run_frames(1, 1'b0, 1'b1, 400);
        add_exp(4, 3, 0);
        cmp_stream("latch", start);
        chk("latch pops", 64'(8'(int'(pop_cnt[4]) - p0)), 64'd3);
        model_ptr = 4;

        // Reset while the second of five payload bytes is on the bus.
        for (int k = 0; k < 5; k++) put_byte(2, k, 8'(8'h61 + k));
        set_len(2, 8'd5);
        base[2] = pop_cnt[2];
        start = cap.size();
        @(posedge clk);
        #1;
        bus.have_msg_bus = N'(1) << 2;
        cyc = 0;
        while (cap.size() - start < 4 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("midreset reach", 64'(cyc < 100), 64'd1);
        @(posedge clk);
        #1;
        chk("midreset byte2 valid", 64'(bus.tx_valid), 64'd1);
        chk("midreset byte2", 64'(bus.tx_data), 64'h62);
        rst = 1'b1;
        bus.have_msg_bus = '0;
        #1;
        chk("midreset tx_valid", 64'(bus.tx_valid), 64'd0);
        chk("midreset rdreq", 64'(bus.rdreq_bus), 64'd0);
        chk("midreset busy", 64'(bus.busy), 64'd0);
        chk("midreset grant", 64'(bus.grant_idx), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        put_byte(0, 0, 8'hB0);
        put_byte(5, 0, 8'hB5);
        set_len(0, 8'd1);
        set_len(5, 8'd1);
        base[0] = pop_cnt[0];
        base[5] = pop_cnt[5];
        start2 = cap.size();
        gq.delete();
        bus.have_msg_bus = (N'(1) << 0) | (N'(1) << 5);
        run_frames(2, 1'b0, 1'b1, 400);
        chk("post-reset first grant", (gq.size() > 0) ? 64'(gq[0]) : 64'hFFFF, 64'd0);
        chk("post-reset second grant", (gq.size() > 1) ? 64'(gq[1]) : 64'hFFFF, 64'd5);
        add_exp(0, 1, 0);
        add_exp(5, 1, 0);
        cmp_stream("post-reset", start2);
        model_ptr = 5;

        // Random rounds with backpressure against the cyclic-priority model.
        for (int r = 0; r < 4; r++) begin
            m = '0;
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 3) == 0) m |= N'(1) << i;
            if (m == '0) m = N'(1) << $urandom_range(0, N - 1);
            for (int i = 0; i < N; i++) begin
                if (m[i]) begin
                    lens[i] = $urandom_range(0, 6);
                    for (int k = 0; k < lens[i]; k++) put_byte(i, k, 8'($urandom));
                    set_len(i, 8'(lens[i]));
                    base[i] = pop_cnt[i];
                end
            end
            order.delete();
            pend = m;
            while (pend != '0) begin
                model_ptr = rr_next(pend, model_ptr);
                order.push_back(model_ptr);
                add_exp(model_ptr, lens[model_ptr], 0);
                pend &= ~(N'(1) << model_ptr);
            end
            start = cap.size();
            gq.delete();
            bus.have_msg_bus = m;
            run_frames(order.size(), 1'b1, 1'b1, 3000);
            chk($sformatf("rand%0d grants", r), 64'(gq.size()), 64'(order.size()));
            for (int j = 0; j < order.size(); j++)
                chk($sformatf("rand%0d grant%0d", r, j),
                    (j < gq.size()) ? 64'(gq[j]) : 64'hFFFF, 64'(order[j]));
            for (int i = 0; i < N; i++)
                if (m[i]) chk($sformatf("rand%0d pops%0d", r, i),
                              64'(8'(pop_cnt[i] - base[i])), 64'(lens[i]));
            cmp_stream($sformatf("rand%0d", r), start);
            bus.have_msg_bus = '0;
        end

        chk("handshake monitor", 64'(mon_err), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
